// File: rtl/reg_file_pkg.sv
// Shared constants, state type and address qualification for the register file.
package reg_file_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DEPTH  = 32;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_e;

    // True when addr names an implemented, writable/readable entry.
    function automatic logic addr_valid(input int unsigned addr,
                                        input int unsigned depth,
                                        input bit          zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Post-reset sequencer: walks every entry once, writing zero, then releases the file.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = RF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rf_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_o = 1'b0;
        clr_we_o    = 1'b0;
        case (state_q)
            CLEAR: begin
                init_busy_o = 1'b1;
                clr_we_o    = 1'b1;
                cnt_d       = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign clr_addr_o = ADDR_W'(cnt_q);

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with optional zero register, write bypass and pending scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] DW,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] DR1,
    output logic [DATA_W-1:0] DR2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              init_busy
);

    localparam bit ZR  = (ZERO_REG != 0);
    localparam bit BYP = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok, iss_ok;
    logic              rd_ok1, rd_ok2, hit1, hit2;

    reg_file_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .init_busy_o (init_busy),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr)
    );

    assign wr_ok  = we && !init_busy && addr_valid(32'(WA), DEPTH, ZR);
    assign iss_ok = issue_en && !init_busy && addr_valid(32'(issue_addr), DEPTH, ZR);

    // Storage is not reset; the clear sequencer owns the write port until RUN.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[WA] <= DW;
        end
    end

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[WA] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rd_ok1 = addr_valid(32'(RA1), DEPTH, ZR);
        rd_ok2 = addr_valid(32'(RA2), DEPTH, ZR);
        hit1   = BYP && wr_ok && (WA == RA1);
        hit2   = BYP && wr_ok && (WA == RA2);
        DR1    = '0;
        DR2    = '0;
        busy1  = 1'b0;
        busy2  = 1'b0;
        if (!init_busy && rd_ok1) begin
            DR1   = hit1 ? DW : mem_q[RA1];
            busy1 = hit1 ? 1'b0 : pend_q[RA1];
        end
        if (!init_busy && rd_ok2) begin
            DR2   = hit2 ? DW : mem_q[RA2];
            busy2 = hit2 ? 1'b0 : pend_q[RA2];
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default, no-bypass and 24-entry builds driven in lockstep against a reference model.
module tb_reg_file_sb;

    logic             clk = 1'b0;
    logic             rst, we, issue_en;
    logic [4:0]       WA, RA1, RA2, issue_addr;
    logic [31:0]      DW;
    logic [2:0][31:0] dr1, dr2;
    logic [2:0]       bz1, bz2, ib;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: instance 0 = defaults, 1 = BYPASS=0, 2 = DEPTH=24
    int          m_depth [3] = '{32, 32, 24};
    bit          m_byp   [3] = '{1'b1, 1'b0, 1'b1};
    int          m_left  [3];
    logic [31:0] m_mem   [3][32];
    bit          m_pend  [3][32];

    always #5 clk = ~clk;

    reg_file_sb u_def (
        .clk(clk), .rst(rst), .we(we), .WA(WA), .DW(DW), .RA1(RA1), .RA2(RA2),
        .DR1(dr1[0]), .DR2(dr2[0]), .issue_en(issue_en), .issue_addr(issue_addr),
        .busy1(bz1[0]), .busy2(bz2[0]), .init_busy(ib[0])
    );

    reg_file_sb #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .we(we), .WA(WA), .DW(DW), .RA1(RA1), .RA2(RA2),
        .DR1(dr1[1]), .DR2(dr2[1]), .issue_en(issue_en), .issue_addr(issue_addr),
        .busy1(bz1[1]), .busy2(bz2[1]), .init_busy(ib[1])
    );

    reg_file_sb #(.DEPTH(24)) u_d24 (
        .clk(clk), .rst(rst), .we(we), .WA(WA), .DW(DW), .RA1(RA1), .RA2(RA2),
        .DR1(dr1[2]), .DR2(dr2[2]), .issue_en(issue_en), .issue_addr(issue_addr),
        .busy1(bz1[2]), .busy2(bz2[2]), .init_busy(ib[2])
    );

    function automatic bit m_valid(int i, logic [4:0] a);
        return (int'(a) < m_depth[i]) && (a != 5'd0);
    endfunction

    function automatic bit m_ib(int i);
        return m_left[i] > 0;
    endfunction

    function automatic logic [31:0] m_dr(int i, logic [4:0] ra);
        if (m_left[i] > 0 || !m_valid(i, ra)) return 32'h0;
        if (m_byp[i] && we && m_valid(i, WA) && WA == ra) return DW;
        return m_mem[i][ra];
    endfunction

    function automatic logic m_busy(int i, logic [4:0] ra);
        if (m_left[i] > 0 || !m_valid(i, ra)) return 1'b0;
        if (m_byp[i] && we && WA == ra) return 1'b0;
        return m_pend[i][ra];
    endfunction

    function automatic void m_update();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_left[i] = m_depth[i];
                for (int a = 0; a < 32; a++) begin
                    m_mem[i][a]  = 32'h0;
                    m_pend[i][a] = 1'b0;
                end
            end else if (m_left[i] > 0) begin
                m_left[i]--;
            end else begin
                if (we && m_valid(i, WA)) begin
                    m_mem[i][WA]  = DW;
                    m_pend[i][WA] = 1'b0;
                end
                if (issue_en && m_valid(i, issue_addr)) m_pend[i][issue_addr] = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic set_idle();
        we = 1'b0; issue_en = 1'b0; WA = '0; DW = '0;
        RA1 = '0; RA2 = '0; issue_addr = '0;
    endtask

    task automatic test_reset();
        int cnt [3] = '{0, 0, 0};
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ib[i]) cnt[i]++;
                vectors++;
                if (ib[i] !== m_ib(i)) begin
                    miscompares++;
                    $display("FAIL reset_init_busy inst%0d cyc%0d: got %b want %b", i, k, ib[i], m_ib(i));
                end
                vectors++;
                if (ib[i] && (dr1[i] !== 32'h0 || bz1[i] !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL clear_forced inst%0d: got dr1=%h busy1=%b want 0/0", i, dr1[i], bz1[i]);
                end
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cnt[i] != m_depth[i]) begin
                miscompares++;
                $display("FAIL clear_length inst%0d: got %0d want %0d", i, cnt[i], m_depth[i]);
            end
        end
        for (int a = 0; a < 32; a++) begin
            RA1 = 5'(a); RA2 = 5'(31 - a);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (dr1[i] !== 32'h0 || dr2[i] !== 32'h0 || bz1[i] !== 1'b0 || bz2[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL post_clear_read inst%0d a%0d: got %h/%h %b%b want 0/0 00",
                             i, a, dr1[i], dr2[i], bz1[i], bz2[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_bypass_write();
        logic [31:0] want [3] = '{32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        set_idle();
        we = 1'b1; WA = 5'd5; DW = 32'hDEADBEEF; RA1 = 5'd5;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dr1[i] !== want[i]) begin
                miscompares++;
                $display("FAIL bypass_same_cycle inst%0d: got %h want %h", i, dr1[i], want[i]);
            end
        end
        tick();
        set_idle();
        RA2 = 5'd5;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dr2[i] !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL write_next_cycle inst%0d: got %h want deadbeef", i, dr2[i]);
            end
        end
        tick();
    endtask

    task automatic test_zero_reg();
        set_idle();
        we = 1'b1; WA = 5'd0; DW = 32'h12345678; issue_en = 1'b1; issue_addr = 5'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (dr1[i] !== 32'h0 || bz1[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL zero_reg inst%0d cyc%0d: got %h/%b want 0/0", i, k, dr1[i], bz1[i]);
                end
            end
            tick();
            set_idle();
        end
    endtask

    task automatic test_scoreboard();
        logic       wantb [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] wantd [3] = '{8'hA5, 8'h00, 8'hA5};
        set_idle();
        issue_en = 1'b1; issue_addr = 5'd7;
        tick();
        set_idle();
        RA1 = 5'd7;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bz1[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL issue_busy inst%0d: got %b want 1", i, bz1[i]);
            end
        end
        tick();
        we = 1'b1; WA = 5'd7; DW = 32'hA5;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bz1[i] !== wantb[i] || dr1[i] !== {24'h0, wantd[i]}) begin
                miscompares++;
                $display("FAIL writeback_bypass inst%0d: got %b/%h want %b/%h", i, bz1[i], dr1[i], wantb[i], wantd[i]);
            end
        end
        tick();
        set_idle();
        RA1 = 5'd7;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bz1[i] !== 1'b0 || dr1[i] !== 32'hA5) begin
                miscompares++;
                $display("FAIL writeback_retire inst%0d: got %b/%h want 0/a5", i, bz1[i], dr1[i]);
            end
        end
        tick();
        we = 1'b1; WA = 5'd9; DW = 32'h99; issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        set_idle();
        RA2 = 5'd9;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bz2[i] !== 1'b1 || dr2[i] !== 32'h99) begin
                miscompares++;
                $display("FAIL issue_wins inst%0d: got %b/%h want 1/99", i, bz2[i], dr2[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int cnt [3] = '{0, 0, 0};
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_left[2] > 0) begin
                we = 1'b1; WA = 5'($urandom_range(1, 23)); DW = $urandom;
                issue_en = 1'b1; issue_addr = 5'($urandom_range(1, 23));
            end else begin
                set_idle();
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (ib[i]) cnt[i]++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cnt[i] != m_depth[i]) begin
                miscompares++;
                $display("FAIL restart_length inst%0d: got %0d want %0d", i, cnt[i], m_depth[i]);
            end
        end
        set_idle();
        for (int a = 0; a < 32; a++) begin
            RA1 = 5'(a); RA2 = 5'(a);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (dr1[i] !== 32'h0 || bz2[i] !== 1'b0 || dr2[i] !== dr1[i]) begin
                    miscompares++;
                    $display("FAIL clear_ignores_we inst%0d a%0d: got %h/%h %b want 0/0 0", i, a, dr1[i], dr2[i], bz2[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_depth_limit();
        logic [31:0] d;
        d = $urandom | 32'h1;
        set_idle();
        we = 1'b1; WA = 5'd30; DW = d; RA1 = 5'd30;
        issue_en = 1'b1; issue_addr = 5'd30;
        @(negedge clk);
        vectors++;
        if (dr1[2] !== 32'h0 || dr1[0] !== d) begin
            miscompares++;
            $display("FAIL depth_drop_same inst2/0: got %h/%h want 0/%h", dr1[2], dr1[0], d);
        end
        tick();
        set_idle();
        RA1 = 5'd30;
        @(negedge clk);
        vectors++;
        if (dr1[2] !== 32'h0 || bz1[2] !== 1'b0 || dr1[0] !== d || bz1[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL depth_drop_next: got d24=%h/%b def=%h/%b want 0/0 %h/1", dr1[2], bz1[2], dr1[0], bz1[0], d);
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(0, 299) == 0);
            we         = $urandom_range(0, 1);
            WA         = 5'($urandom);
            DW         = $urandom;
            issue_en   = $urandom_range(0, 1);
            issue_addr = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom);
            RA1        = ($urandom_range(0, 2) == 0) ? WA : 5'($urandom);
            RA2        = ($urandom_range(0, 3) == 0) ? RA1 : 5'($urandom);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (dr1[i] !== m_dr(i, RA1) || dr2[i] !== m_dr(i, RA2) ||
                    bz1[i] !== m_busy(i, RA1) || bz2[i] !== m_busy(i, RA2) || ib[i] !== m_ib(i)) begin
                    miscompares++;
                    $display("FAIL random inst%0d cyc%0d: got %h %h %b%b %b want %h %h %b%b %b", i, k,
                             dr1[i], dr2[i], bz1[i], bz2[i], ib[i],
                             m_dr(i, RA1), m_dr(i, RA2), m_busy(i, RA1), m_busy(i, RA2), m_ib(i));
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass_write();
        test_zero_reg();
        test_scoreboard();
        test_depth_limit();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
